// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared types and constants for the single-cabin elevator scheduler.
//   state_t            : controller state (IDLE, MOVE, DOOR)
//   FLOOR_W            : width of a floor number (floors are numbered from 1)
//   FLOOR_MIN/MAX      : lowest and highest floor of the building model
//   DIR_UP/DIR_DN      : encodings of the dir_up output
// ---------------------------------------------------------------------------
package elevator_pkg;

   localparam int                 FLOOR_W   = 3;
   localparam logic [FLOOR_W-1:0] FLOOR_MIN = 3'd1;
   localparam logic [FLOOR_W-1:0] FLOOR_MAX = 3'd7;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      DOOR = 2'd2
   } state_t;

endpackage : elevator_pkg

// File: rtl/floor_req_reduce.sv
// ---------------------------------------------------------------------------
// floor_req_reduce
// Purely combinational request folding. Each floor owns two passenger slots
// in each of the up/down vectors; a floor requests service in a direction if
// either slot is set. Bit i of every output vector refers to floor i+1.
// Ports:
//   up_passenger   in  2*FLOORS  up slots, floor f at bits 2(f-1)+:2
//   down_passenger in  2*FLOORS  down slots, same layout
//   floor          in  FLOOR_W   reference floor for the above/below masks
//   up_req         out FLOORS    per-floor up request (top floor forced 0)
//   dn_req         out FLOORS    per-floor down request (bottom floor forced 0)
//   any_req        out FLOORS    up_req | dn_req
//   above          out FLOORS    any_req restricted to floors > floor
//   below          out FLOORS    any_req restricted to floors < floor
// ---------------------------------------------------------------------------
module floor_req_reduce
   import elevator_pkg::*;
#(
   parameter int FLOORS = int'(FLOOR_MAX)
) (
   input  logic [2*FLOORS-1:0] up_passenger,
   input  logic [2*FLOORS-1:0] down_passenger,
   input  logic [FLOOR_W-1:0]  floor,
   output logic [FLOORS-1:0]   up_req,
   output logic [FLOORS-1:0]   dn_req,
   output logic [FLOORS-1:0]   any_req,
   output logic [FLOORS-1:0]   above,
   output logic [FLOORS-1:0]   below
);

   always_comb begin
      for (int i = 0; i < FLOORS; i++) begin
         up_req[i] = |up_passenger[2*i +: 2];
         dn_req[i] = |down_passenger[2*i +: 2];
      end
      // Nobody can travel up from the top floor or down from the bottom one,
      // so those slots are treated as noise and never attract the cabin.
      up_req[FLOORS-1] = 1'b0;
      dn_req[0]        = 1'b0;
   end

   assign any_req = up_req | dn_req;

   always_comb begin
      for (int i = 0; i < FLOORS; i++) begin
         above[i] = any_req[i] && (FLOOR_W'(i + 1) > floor);
         below[i] = any_req[i] && (FLOOR_W'(i + 1) < floor);
      end
   end

endmodule : floor_req_reduce

// File: rtl/elevator_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_scheduler
// Single-cabin LOOK scheduler: keeps travelling in the current direction
// while requests remain beyond the cabin, stops at floors that want to go the
// same way (or at the last request in that direction), then reverses or idles.
// Ports:
//   clk            in  1         system clock, rising edge
//   rst_n          in  1         asynchronous active-low reset
//   up_passenger   in  2*FLOORS  up slots, floor f at bits 2(f-1)+:2
//   down_passenger in  2*FLOORS  down slots, same layout
//   door_hold      in  1         keeps the door open while high in DOOR
//   current_floor  out FLOOR_W   cabin floor, FLOOR_MIN..FLOORS
//   dir_up         out 1         travel direction, 1 = up
//   moving         out 1         cabin is travelling between floors
//   door_open      out 1         door is open at current_floor
//   serve_pulse    out FLOORS    one-hot, first DOOR cycle at a floor only
// ---------------------------------------------------------------------------
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int FLOORS      = int'(FLOOR_MAX),
   parameter int MOVE_CYCLES = 4,
   parameter int DOOR_CYCLES = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2*FLOORS-1:0] up_passenger,
   input  logic [2*FLOORS-1:0] down_passenger,
   input  logic                door_hold,
   output logic [FLOOR_W-1:0]  current_floor,
   output logic                dir_up,
   output logic                moving,
   output logic                door_open,
   output logic [FLOORS-1:0]   serve_pulse
);

   localparam int MOVE_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
   localparam int DOOR_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   localparam logic [MOVE_W-1:0]  MOVE_LAST = MOVE_W'(MOVE_CYCLES - 1);
   localparam logic [DOOR_W-1:0]  DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(FLOORS);

   // ------------------------------------------------------------------------
   // State and next-state signals
   // ------------------------------------------------------------------------
   state_t               state,         state_nxt;
   logic [MOVE_W-1:0]    move_cnt,      move_cnt_nxt;
   logic [DOOR_W-1:0]    door_cnt,      door_cnt_nxt;
   logic [FLOOR_W-1:0]   floor_nxt;
   logic                 dir_nxt;
   logic [FLOORS-1:0]    serve_nxt;

   // ------------------------------------------------------------------------
   // Request view relative to the current floor
   // ------------------------------------------------------------------------
   logic [FLOORS-1:0] up_req, dn_req, any_req, above, below;

   floor_req_reduce #(
      .FLOORS (FLOORS)
   ) u_reduce (
      .up_passenger   (up_passenger),
      .down_passenger (down_passenger),
      .floor          (current_floor),
      .up_req         (up_req),
      .dn_req         (dn_req),
      .any_req        (any_req),
      .above          (above),
      .below          (below)
   );

   logic [FLOOR_W-1:0] arrive_floor;
   logic [FLOORS-1:0]  cur_oh, arr_oh;
   logic               here_any, above_any, below_any;
   logic               arr_dir_req, arr_any, beyond_arr, arr_stop;
   logic               ahead_any, behind_any;

   // Floor reached at the end of the current one-floor hop. The guards keep
   // the cabin inside the building even if requests vanish mid-hop.
   always_comb begin
      arrive_floor = current_floor;
      if (dir_up && (current_floor != TOP_FLOOR)) begin
         arrive_floor = current_floor + 1'b1;
      end else if (!dir_up && (current_floor != FLOOR_MIN)) begin
         arrive_floor = current_floor - 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < FLOORS; i++) begin
         cur_oh[i] = (current_floor == FLOOR_W'(i + 1));
         arr_oh[i] = (arrive_floor  == FLOOR_W'(i + 1));
      end
   end

   assign here_any   = |(any_req & cur_oh);
   assign above_any  = |above;
   assign below_any  = |below;
   assign ahead_any  = dir_up ? above_any : below_any;
   assign behind_any = dir_up ? below_any : above_any;

   // The stop decision for the floor being reached is made on the edge that
   // moves the cabin there, so the next segment starts without a bubble.
   // Floors beyond the arrival floor are the ones beyond the current floor
   // minus the arrival floor itself.
   assign arr_dir_req = dir_up ? |(up_req & arr_oh) : |(dn_req & arr_oh);
   assign arr_any     = |(any_req & arr_oh);
   assign beyond_arr  = |((dir_up ? above : below) & ~arr_oh);
   assign arr_stop    = arr_dir_req || (!beyond_arr && arr_any);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case so that no path
      // leaves one unassigned, which would otherwise infer a latch.
      state_nxt    = state;
      move_cnt_nxt = move_cnt;
      door_cnt_nxt = door_cnt;
      floor_nxt    = current_floor;
      dir_nxt      = dir_up;
      serve_nxt    = '0;

      unique case (state)
         IDLE: begin
            if (here_any) begin
               state_nxt    = DOOR;
               door_cnt_nxt = '0;
               serve_nxt    = cur_oh;
            end else if (above_any) begin
               state_nxt    = MOVE;
               dir_nxt      = DIR_UP;
               move_cnt_nxt = '0;
            end else if (below_any) begin
               state_nxt    = MOVE;
               dir_nxt      = DIR_DN;
               move_cnt_nxt = '0;
            end
         end

         MOVE: begin
            if (move_cnt == MOVE_LAST) begin
               move_cnt_nxt = '0;
               floor_nxt    = arrive_floor;
               if (arrive_floor == TOP_FLOOR) begin
                  dir_nxt = DIR_DN;
               end else if (arrive_floor == FLOOR_MIN) begin
                  dir_nxt = DIR_UP;
               end
               if (arr_stop) begin
                  state_nxt    = DOOR;
                  door_cnt_nxt = '0;
                  serve_nxt    = arr_oh;
               end else if (!beyond_arr) begin
                  state_nxt = IDLE;
               end
            end else begin
               move_cnt_nxt = move_cnt + 1'b1;
            end
         end

         DOOR: begin
            if (door_hold) begin
               door_cnt_nxt = '0;
            end else if (door_cnt == DOOR_LAST) begin
               door_cnt_nxt = '0;
               if (ahead_any) begin
                  state_nxt    = MOVE;
                  move_cnt_nxt = '0;
               end else if (behind_any) begin
                  state_nxt    = MOVE;
                  dir_nxt      = ~dir_up;
                  move_cnt_nxt = '0;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               door_cnt_nxt = door_cnt + 1'b1;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         move_cnt      <= '0;
         door_cnt      <= '0;
         current_floor <= FLOOR_MIN;
         dir_up        <= DIR_UP;
         serve_pulse   <= '0;
      end else begin
         // NOTE: non-blocking assignments let every register sample the
         // pre-edge values, independent of statement order.
         state         <= state_nxt;
         move_cnt      <= move_cnt_nxt;
         door_cnt      <= door_cnt_nxt;
         current_floor <= floor_nxt;
         dir_up        <= dir_nxt;
         serve_pulse   <= serve_nxt;
      end
   end

   assign moving    = (state == MOVE);
   assign door_open = (state == DOOR);

endmodule : elevator_scheduler
